// File: rtl/ibex_fetch_requester.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ibex_fetch_requester                                            |
// | Summary  : Word-aligned instruction fetch initiator feeding the fetch FIFO |
// |            and dropping responses made stale by a branch.                  |
// | Options  : IBEX_FETCH_REQ_DISCARD_CNT_EN enables the discard counter.      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module ibex_fetch_requester #(
  parameter int unsigned NUM_REQS = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_i,
  input  logic                branch_i,
  input  logic [31:0]         addr_i,
  input  logic [NUM_REQS-1:0] fifo_busy_i,
  output logic                fifo_clear_o,
  output logic                fifo_valid_o,
  output logic [31:0]         fifo_addr_o,
  output logic [31:0]         fifo_rdata_o,
  output logic                fifo_err_o,
  output logic                instr_req_o,
  input  logic                instr_gnt_i,
  output logic [31:0]         instr_addr_o,
  input  logic                instr_rvalid_i,
  input  logic [31:0]         instr_rdata_i,
  input  logic                instr_err_i,
  output logic                busy_o,
  output logic [31:0]         discard_cnt_o
);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_GNT = 1'b1
  } state_e;

  state_e              state_q;
  logic [NUM_REQS-1:0] out_q;
  logic [NUM_REQS-1:0] disc_q;
  logic [31:0]         fetch_addr_q;

  logic                w_can_issue;
  logic                w_gnt;
  logic [31:0]         w_branch_addr;
  logic [NUM_REQS-1:0] w_out_shift;
  logic [NUM_REQS-1:0] w_disc_shift;
  logic [NUM_REQS-1:0] w_out_next;
  logic [NUM_REQS-1:0] w_disc_next;
  logic [1:0]          w_unused_addr;

  assign w_branch_addr = {addr_i[31:2], 2'b00};
  assign w_unused_addr = addr_i[1:0];

  // The top slot being occupied means every bus slot is in flight.
  assign w_can_issue  = (req_i | branch_i) & ~(&fifo_busy_i) & ~out_q[NUM_REQS-1];
  assign instr_req_o  = (state_q == WAIT_GNT) | w_can_issue;
  assign w_gnt        = instr_req_o & instr_gnt_i;
  assign instr_addr_o = branch_i ? w_branch_addr : fetch_addr_q;

  assign fifo_clear_o = branch_i;
  assign fifo_addr_o  = addr_i;
  assign fifo_valid_o = instr_rvalid_i & ~disc_q[0] & ~branch_i;
  assign fifo_rdata_o = instr_rdata_i;
  assign fifo_err_o   = instr_err_i;
  assign busy_o       = |out_q;

  // Retire first, then mark stale slots, then append the newly granted slot.
  always_comb begin
    w_out_shift  = instr_rvalid_i ? (out_q >> 1)  : out_q;
    w_disc_shift = instr_rvalid_i ? (disc_q >> 1) : disc_q;
    w_disc_next  = w_disc_shift | (branch_i ? w_out_shift : '0);
    w_out_next   = w_out_shift;
    if (w_gnt) begin
      w_out_next = (w_out_shift << 1) | NUM_REQS'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      out_q        <= '0;
      disc_q       <= '0;
      fetch_addr_q <= '0;
    end else begin
      state_q <= (instr_req_o & ~instr_gnt_i) ? WAIT_GNT : IDLE;
      out_q   <= w_out_next;
      disc_q  <= w_disc_next;
      if (w_gnt) begin
        fetch_addr_q <= instr_addr_o + 32'd4;
      end else if (branch_i) begin
        fetch_addr_q <= w_branch_addr;
      end
    end
  end

`ifdef IBEX_FETCH_REQ_DISCARD_CNT_EN
  logic        w_drop;
  logic [31:0] r_discard_cnt;

  assign w_drop = instr_rvalid_i & (disc_q[0] | branch_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_discard_cnt <= '0;
    end else if (w_drop && (r_discard_cnt != 32'hFFFF_FFFF)) begin
      r_discard_cnt <= r_discard_cnt + 32'd1;
    end
  end

  assign discard_cnt_o = r_discard_cnt;
`else
  assign discard_cnt_o = '0;
`endif

  a_rvalid_outstanding: assert property (
    @(posedge clk_i) disable iff (!rst_ni) instr_rvalid_i |-> (|out_q));

  a_push_when_full: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    !(fifo_valid_o & fifo_busy_i[NUM_REQS-1] & ~fifo_clear_o));

endmodule
`default_nettype wire

// File: tb/tb_ibex_fetch_requester.sv
`default_nettype none
// Directed self-checking bench for ibex_fetch_requester (NUM_REQS = 2).
module tb_ibex_fetch_requester;

  localparam int unsigned NUM_REQS = 2;

  logic                clk_i = 1'b0;
  logic                rst_ni;
  logic                req_i;
  logic                branch_i;
  logic [31:0]         addr_i;
  logic [NUM_REQS-1:0] fifo_busy_i;
  logic                fifo_clear_o;
  logic                fifo_valid_o;
  logic [31:0]         fifo_addr_o;
  logic [31:0]         fifo_rdata_o;
  logic                fifo_err_o;
  logic                instr_req_o;
  logic                instr_gnt_i;
  logic [31:0]         instr_addr_o;
  logic                instr_rvalid_i;
  logic [31:0]         instr_rdata_i;
  logic                instr_err_i;
  logic                busy_o;
  logic [31:0]         discard_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef IBEX_FETCH_REQ_DISCARD_CNT_EN
  localparam logic [31:0] CNT1 = 32'd1;
  localparam logic [31:0] CNT2 = 32'd2;
`else
  localparam logic [31:0] CNT1 = 32'd0;
  localparam logic [31:0] CNT2 = 32'd0;
`endif

  ibex_fetch_requester #(.NUM_REQS(NUM_REQS)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_i          (req_i),
    .branch_i       (branch_i),
    .addr_i         (addr_i),
    .fifo_busy_i    (fifo_busy_i),
    .fifo_clear_o   (fifo_clear_o),
    .fifo_valid_o   (fifo_valid_o),
    .fifo_addr_o    (fifo_addr_o),
    .fifo_rdata_o   (fifo_rdata_o),
    .fifo_err_o     (fifo_err_o),
    .instr_req_o    (instr_req_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_addr_o   (instr_addr_o),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .instr_err_i    (instr_err_i),
    .busy_o         (busy_o),
    .discard_cnt_o  (discard_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs just after the rising edge, then settle.
  task automatic drive(input logic req, input logic br, input logic [31:0] baddr,
                       input logic [1:0] fbusy, input logic gnt, input logic rv,
                       input logic [31:0] rdata, input logic err);
    req_i          = req;
    branch_i       = br;
    addr_i         = baddr;
    fifo_busy_i    = fbusy;
    instr_gnt_i    = gnt;
    instr_rvalid_i = rv;
    instr_rdata_i  = rdata;
    instr_err_i    = err;
    #1;
  endtask

  task automatic next_cycle;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni = 1'b0;
    drive(0, 0, 32'h0, 2'b00, 0, 0, 32'h0, 0);
    repeat (2) @(posedge clk_i);
    #1;
    check_eq("rst_req",   {31'd0, instr_req_o},  32'd0);
    check_eq("rst_addr",  instr_addr_o,          32'h0);
    check_eq("rst_valid", {31'd0, fifo_valid_o}, 32'd0);
    check_eq("rst_busy",  {31'd0, busy_o},       32'd0);
    check_eq("rst_cnt",   discard_cnt_o,         32'd0);

    // Streaming fetch, always granted, response one cycle later
    next_cycle();
    rst_ni = 1'b1;
    drive(1, 0, 32'h0, 2'b00, 1, 0, 32'h0, 0);
    check_eq("A_req",   {31'd0, instr_req_o}, 32'd1);
    check_eq("A_addr",  instr_addr_o,         32'h0);
    next_cycle();
    drive(1, 0, 32'h0, 2'b00, 1, 1, 32'hD000_0000, 0);
    check_eq("B_addr",  instr_addr_o,          32'h4);
    check_eq("B_valid", {31'd0, fifo_valid_o}, 32'd1);
    check_eq("B_rdata", fifo_rdata_o,          32'hD000_0000);
    check_eq("B_busy",  {31'd0, busy_o},       32'd1);
    next_cycle();
    drive(1, 0, 32'h0, 2'b00, 1, 1, 32'hD000_0001, 0);
    check_eq("C_addr",  instr_addr_o,          32'h8);
    check_eq("C_rdata", fifo_rdata_o,          32'hD000_0001);
    next_cycle();
    drive(1, 0, 32'h0, 2'b00, 1, 1, 32'hD000_0002, 0);
    check_eq("D_addr",  instr_addr_o,          32'hC);
    check_eq("D_valid", {31'd0, fifo_valid_o}, 32'd1);

    // Grant withheld for three cycles at 0x10
    next_cycle();
    drive(1, 0, 32'h0, 2'b00, 0, 1, 32'hD000_0003, 0);
    check_eq("E_req",   {31'd0, instr_req_o},  32'd1);
    check_eq("E_addr",  instr_addr_o,          32'h10);
    check_eq("E_valid", {31'd0, fifo_valid_o}, 32'd1);
    next_cycle();
    drive(0, 0, 32'h0, 2'b00, 0, 0, 32'h0, 0);
    check_eq("F_req_hold", {31'd0, instr_req_o}, 32'd1);
    check_eq("F_addr",     instr_addr_o,         32'h10);
    next_cycle();
    drive(1, 0, 32'h0, 2'b00, 0, 0, 32'h0, 0);
    check_eq("G_addr",  instr_addr_o, 32'h10);
    next_cycle();
    drive(1, 0, 32'h0, 2'b00, 1, 0, 32'h0, 0);
    check_eq("H_req",   {31'd0, instr_req_o}, 32'd1);
    check_eq("H_addr",  instr_addr_o,         32'h10);
    next_cycle();
    drive(1, 0, 32'h0, 2'b00, 1, 1, 32'hD000_0004, 0);
    check_eq("I_addr",  instr_addr_o,          32'h14);
    check_eq("I_valid", {31'd0, fifo_valid_o}, 32'd1);
    next_cycle();
    drive(1, 0, 32'h0, 2'b00, 1, 0, 32'h0, 0);
    check_eq("J_addr",  instr_addr_o, 32'h18);

    // Branch with two requests (0x14, 0x18) in flight
    next_cycle();
    drive(1, 1, 32'h0000_0102, 2'b00, 0, 0, 32'h0, 0);
    check_eq("K_busy",  {31'd0, busy_o},       32'd1);
    check_eq("K_addr",  instr_addr_o,          32'h100);
    check_eq("K_clear", {31'd0, fifo_clear_o}, 32'd1);
    check_eq("K_faddr", fifo_addr_o,           32'h102);
    check_eq("K_req",   {31'd0, instr_req_o},  32'd0);
    next_cycle();
    drive(1, 0, 32'h0, 2'b00, 0, 1, 32'hD000_0005, 0);
    check_eq("L_valid", {31'd0, fifo_valid_o}, 32'd0);
    check_eq("L_req",   {31'd0, instr_req_o},  32'd0);
    next_cycle();
    drive(1, 0, 32'h0, 2'b00, 1, 1, 32'hD000_0006, 0);
    check_eq("M_valid", {31'd0, fifo_valid_o}, 32'd0);
    check_eq("M_req",   {31'd0, instr_req_o},  32'd1);
    check_eq("M_addr",  instr_addr_o,          32'h100);
    check_eq("M_cnt",   discard_cnt_o,         CNT1);
    next_cycle();
    drive(0, 0, 32'h0, 2'b00, 0, 1, 32'hD000_0007, 0);
    check_eq("N_valid", {31'd0, fifo_valid_o}, 32'd1);
    check_eq("N_rdata", fifo_rdata_o,          32'hD000_0007);
    check_eq("N_cnt",   discard_cnt_o,         CNT2);
    check_eq("N_req",   {31'd0, instr_req_o},  32'd0);

    // FIFO upper entries busy
    next_cycle();
    check_eq("O_idle_busy", {31'd0, busy_o}, 32'd0);
    drive(1, 0, 32'h0, 2'b11, 0, 0, 32'h0, 0);
    check_eq("O_req_blocked", {31'd0, instr_req_o}, 32'd0);
    next_cycle();
    drive(1, 0, 32'h0, 2'b00, 0, 0, 32'h0, 0);
    check_eq("P_req",   {31'd0, instr_req_o}, 32'd1);
    check_eq("P_addr",  instr_addr_o,         32'h104);
    next_cycle();
    drive(1, 0, 32'h0, 2'b11, 0, 0, 32'h0, 0);
    check_eq("Q_req_hold", {31'd0, instr_req_o}, 32'd1);
    next_cycle();
    drive(1, 0, 32'h0, 2'b11, 1, 0, 32'h0, 0);
    check_eq("R_req",   {31'd0, instr_req_o}, 32'd1);
    check_eq("R_addr",  instr_addr_o,         32'h104);
    next_cycle();
    drive(1, 0, 32'h0, 2'b11, 0, 0, 32'h0, 0);
    check_eq("S_req_blocked", {31'd0, instr_req_o}, 32'd0);
    next_cycle();
    drive(1, 0, 32'h0, 2'b00, 1, 1, 32'hD000_0008, 0);
    check_eq("T_req_resume", {31'd0, instr_req_o},  32'd1);
    check_eq("T_addr",       instr_addr_o,          32'h108);
    check_eq("T_valid",      {31'd0, fifo_valid_o}, 32'd1);

    // Error response still pushed, fetching continues
    next_cycle();
    drive(0, 0, 32'h0, 2'b00, 0, 1, 32'hD000_0009, 1);
    check_eq("U_valid", {31'd0, fifo_valid_o}, 32'd1);
    check_eq("U_err",   {31'd0, fifo_err_o},   32'd1);

    // Address wrap at the top of memory
    next_cycle();
    drive(1, 1, 32'hFFFF_FFFE, 2'b00, 0, 0, 32'h0, 0);
    check_eq("V_req",   {31'd0, instr_req_o}, 32'd1);
    check_eq("V_addr",  instr_addr_o,         32'hFFFF_FFFC);
    next_cycle();
    drive(1, 0, 32'h0, 2'b00, 1, 0, 32'h0, 0);
    check_eq("W_addr",  instr_addr_o, 32'hFFFF_FFFC);
    next_cycle();
    drive(1, 0, 32'h0, 2'b00, 0, 1, 32'hD000_000A, 0);
    check_eq("X_wrap_addr", instr_addr_o,          32'h0);
    check_eq("X_valid",     {31'd0, fifo_valid_o}, 32'd1);
    check_eq("X_err",       {31'd0, fifo_err_o},   32'd0);

    next_cycle();
    drive(0, 0, 32'h0, 2'b00, 0, 0, 32'h0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
